// File: rtl/dmem_pkg.sv
// Shared encodings and lane/extension helpers for the byte-addressed data memory.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic {CLEAR, READY} state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_B:  lane_mask = 4'b0001 << a;
      SIZE_H:  lane_mask = a[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_H:  is_misaligned = a[0];
      SIZE_W:  is_misaligned = |a;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  load_extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_H:  load_extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_resp_pipe.sv
// Fixed-latency response shift register; stage 0 captures at the acceptance edge.
module dmem_resp_pipe #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_error,
  input  logic [31:0] in_rdata,
  output logic        out_valid,
  output logic        out_error,
  output logic [31:0] out_rdata
);

  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] err;
  logic [31:0]        rd [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    err[0] <= in_error;
    rd[0]  <= in_rdata;
    for (int i = 1; i < LATENCY; i++) begin
      err[i] <= err[i-1];
      rd[i]  <= rd[i-1];
    end
  end

  // Payload is not reset, so qualify it with the valid bit to keep outputs clean.
  assign out_valid = vld[LATENCY-1];
  assign out_error = vld[LATENCY-1] & err[LATENCY-1];
  assign out_rdata = vld[LATENCY-1] ? rd[LATENCY-1] : 32'h0;

endmodule

// File: rtl/dmem_pipelined_bytewise.sv
// Byte-addressed little-endian data memory with post-reset clear engine and fixed-latency responses.
//  state | meaning
//  CLEAR | zeroing word[clear_idx] each cycle, requests refused
//  READY | array cleared, one request accepted per cycle
module dmem_pipelined_bytewise
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        init_done
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e            state;
  logic [IDX_W-1:0]  clear_idx;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              err;
  logic [IDX_W-1:0]  widx;
  logic [3:0]        be;
  logic [31:0]       wrep;
  logic [31:0]       rword;
  logic [31:0]       ldata;
  logic              unused_addr;

  assign accept      = req_valid & req_ready;
  assign widx        = req_addr[IDX_W+1:2];
  assign unused_addr = ^req_addr[31:IDX_W+2];
  assign err         = (req_size == SIZE_X) | is_misaligned(req_size, req_addr[1:0]);
  assign be          = (accept & req_write & ~err) ? lane_mask(req_size, req_addr[1:0]) : 4'b0000;

  always_comb begin
    wrep = req_wdata;
    case (req_size)
      SIZE_B:  wrep = {4{req_wdata[7:0]}};
      SIZE_H:  wrep = {2{req_wdata[15:0]}};
      default: wrep = req_wdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clear_idx <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clear_idx <= clear_idx + 1'b1;
          if (clear_idx == IDX_W'(DEPTH - 1)) begin
            state     <= READY;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        default: begin
          state <= READY;
        end
      endcase
    end
  end

  // Storage carries no reset; the clear engine owns the write port while in CLEAR.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clear_idx] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  assign rword = mem[widx];
  assign ldata = (req_write | err) ? 32'h0
                                   : load_extract(rword, req_size, req_addr[1:0], req_unsigned);

  dmem_resp_pipe #(.LATENCY(LATENCY)) u_resp_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_error  (err),
    .in_rdata  (ldata),
    .out_valid (resp_valid),
    .out_error (resp_error),
    .out_rdata (resp_rdata)
  );

endmodule

// File: tb/tb_dmem_pipelined_bytewise.sv
// Directed bench: LATENCY=1 instance for functional cases, LATENCY=3 instance for pipeline timing.
module tb_dmem_pipelined_bytewise;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_error, init_done;
  logic [31:0] resp_rdata;

  logic        r3_valid = 1'b0, r3_write = 1'b0, r3_unsigned = 1'b0;
  logic [1:0]  r3_size = 2'b10;
  logic [31:0] r3_addr = '0, r3_wdata = '0;
  logic        r3_ready, p3_valid, p3_error, p3_init;
  logic [31:0] p3_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_pipelined_bytewise #(.DEPTH(DEPTH), .LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error), .init_done(init_done)
  );

  dmem_pipelined_bytewise #(.DEPTH(DEPTH), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(r3_ready), .req_write(r3_write),
    .req_size(r3_size), .req_unsigned(r3_unsigned), .req_addr(r3_addr), .req_wdata(r3_wdata),
    .resp_valid(p3_valid), .resp_rdata(p3_rdata), .resp_error(p3_error), .init_done(p3_init)
  );

  // One request on the LATENCY=1 instance; response is sampled just after the accept edge.
  task automatic xact(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                      input logic [31:0] wd, output logic v, output logic e, output logic [31:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    v = resp_valid; e = resp_error; rd = resp_rdata;
    req_valid = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int cnt;
    cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    while (cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (req_ready) break;
    end
    checks++;
    if (cnt !== DEPTH) begin
      errors++;
      $display("FAIL %s_clear_len: got %0d cycles, expected %0d", tag, cnt, DEPTH);
    end
    checks++;
    if (r3_ready !== 1'b1 || init_done !== 1'b1 || p3_init !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_after_clear: got r3_ready=%b init=%b init3=%b, expected 1 1 1",
               tag, r3_ready, init_done, p3_init);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({req_ready, resp_valid, resp_error, init_done, resp_rdata} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b err=%b done=%b rdata=%h, expected all 0",
               req_ready, resp_valid, resp_error, init_done, resp_rdata);
    end
    wait_clear("reset");
  endtask

  task automatic test_cleared();
    logic [31:0] addrs [3];
    logic v, e;
    logic [31:0] rd;
    addrs[0] = 32'h0; addrs[1] = 32'h800; addrs[2] = 32'hFFC;
    for (int i = 0; i < 3; i++) begin
      xact(1'b0, 2'b10, 1'b0, addrs[i], 32'h0, v, e, rd);
      checks++;
      if (v !== 1'b1 || e !== 1'b0 || rd !== 32'h0) begin
        errors++;
        $display("FAIL cleared_lw_%h: got v=%b e=%b rd=%h, expected 1 0 00000000", addrs[i], v, e, rd);
      end
    end
  endtask

  task automatic test_loads();
    logic [1:0]  sz  [4];
    logic        un  [4];
    logic [31:0] ad  [4];
    logic [31:0] exp [4];
    logic v, e;
    logic [31:0] rd;
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, v, e, rd);
    checks++;
    if (v !== 1'b1 || e !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sw_resp: got v=%b e=%b rd=%h, expected 1 0 00000000", v, e, rd);
    end
    sz[0] = 2'b00; un[0] = 1'b0; ad[0] = 32'h13; exp[0] = 32'hFFFFFFDE;
    sz[1] = 2'b00; un[1] = 1'b1; ad[1] = 32'h13; exp[1] = 32'h000000DE;
    sz[2] = 2'b01; un[2] = 1'b0; ad[2] = 32'h10; exp[2] = 32'hFFFFBEEF;
    sz[3] = 2'b01; un[3] = 1'b1; ad[3] = 32'h12; exp[3] = 32'h0000DEAD;
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, sz[i], un[i], ad[i], 32'h0, v, e, rd);
      checks++;
      if (v !== 1'b1 || e !== 1'b0 || rd !== exp[i]) begin
        errors++;
        $display("FAIL load_%0d: got v=%b e=%b rd=%h, expected 1 0 %h", i, v, e, rd, exp[i]);
      end
    end
  endtask

  task automatic test_partial_stores();
    logic v, e;
    logic [31:0] rd;
    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, v, e, rd);
    xact(1'b1, 2'b00, 1'b0, 32'h21, 32'hABCDEF5A, v, e, rd);
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, v, e, rd);
    checks++;
    if (rd !== 32'h11225A44) begin
      errors++;
      $display("FAIL sb_merge: got %h, expected 11225A44", rd);
    end
    xact(1'b1, 2'b01, 1'b0, 32'h22, 32'h98761234, v, e, rd);
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, v, e, rd);
    checks++;
    if (rd !== 32'h12345A44) begin
      errors++;
      $display("FAIL sh_merge: got %h, expected 12345A44", rd);
    end
  endtask

  task automatic test_errors();
    logic        wr [3];
    logic [1:0]  sz [3];
    logic [31:0] ad [3];
    logic v, e;
    logic [31:0] rd;
    wr[0] = 1'b0; sz[0] = 2'b10; ad[0] = 32'h21;
    wr[1] = 1'b1; sz[1] = 2'b01; ad[1] = 32'h23;
    wr[2] = 1'b1; sz[2] = 2'b11; ad[2] = 32'h20;
    for (int i = 0; i < 3; i++) begin
      xact(wr[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF, v, e, rd);
      checks++;
      if (v !== 1'b1 || e !== 1'b1 || rd !== 32'h0) begin
        errors++;
        $display("FAIL err_%0d: got v=%b e=%b rd=%h, expected 1 1 00000000", i, v, e, rd);
      end
    end
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, v, e, rd);
    checks++;
    if (e !== 1'b0 || rd !== 32'h12345A44) begin
      errors++;
      $display("FAIL err_no_write: got e=%b rd=%h, expected 0 12345A44", e, rd);
    end
  endtask

  task automatic test_wrap();
    logic v, e;
    logic [31:0] rd;
    xact(1'b1, 2'b10, 1'b0, 32'h1000, 32'h7, v, e, rd);
    xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, v, e, rd);
    checks++;
    if (rd !== 32'h7) begin
      errors++;
      $display("FAIL addr_wrap: got %h, expected 00000007", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic        ev [6];
    logic [31:0] ed [6];
    // Accepts at edges 1..3; responses after edges 3..5 (LATENCY=3).
    ev[0] = 1'b0; ed[0] = 32'h0;
    ev[1] = 1'b0; ed[1] = 32'h0;
    ev[2] = 1'b1; ed[2] = 32'h0;
    ev[3] = 1'b1; ed[3] = 32'hCAFEF00D;
    ev[4] = 1'b1; ed[4] = 32'hCAFEF00D;
    ev[5] = 1'b0; ed[5] = 32'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      r3_valid = (k < 3); r3_write = (k == 0); r3_size = 2'b10; r3_unsigned = 1'b0;
      r3_addr = 32'h40; r3_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      checks++;
      if (p3_valid !== ev[k] || p3_rdata !== ed[k] || p3_error !== 1'b0) begin
        errors++;
        $display("FAIL b2b_edge%0d: got v=%b e=%b rd=%h, expected %b 0 %h",
                 k + 1, p3_valid, p3_error, p3_rdata, ev[k], ed[k]);
      end
    end
    r3_valid = 1'b0;
  endtask

  task automatic test_rst_midstream();
    logic seen;
    logic v, e;
    logic [31:0] rd;
    seen = 1'b0;
    @(negedge clk);
    r3_valid = 1'b1; r3_write = 1'b0; r3_size = 2'b10; r3_addr = 32'h40;
    @(posedge clk);
    #1;
    r3_valid = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (p3_valid || resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_drop: got resp_valid seen=%b, expected 0", seen);
    end
    wait_clear("midrst");
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, v, e, rd);
    checks++;
    if (v !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL reclear: got v=%b rd=%h, expected 1 00000000", v, rd);
    end
  endtask

  initial begin
    test_reset();
    test_cleared();
    test_loads();
    test_partial_stores();
    test_errors();
    test_wrap();
    test_back_to_back();
    test_rst_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
